// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bus between the memory stage (master) and the dcache (slave).
interface mem_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [DATA_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: dcache request, stall until dhit,
// writeback select, sticky halt and a saturating stall-cycle counter.
module mem_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             memtoreg_in,
    input  logic                   regwrite_in,
    input  logic                   dmemREN_in,
    input  logic                   dmemWEN_in,
    input  logic                   halt_in,
    input  logic [DATA_W-1:0]      rdat2_in,
    input  logic [DATA_W-1:0]      npc_in,
    input  logic [DATA_W-1:0]      aluResult_in,
    input  logic [4:0]             branchDest_in,
    input  logic [DATA_W-1:0]      upper16_in,
    mem_wb_stage_if.master         dbus,
    output logic                   mem_stall,
    output logic                   wb_regwrite,
    output logic [4:0]             wb_wsel,
    output logic [DATA_W-1:0]      wb_wdat,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {
        RUN,
        WAIT_HIT,
        HALTED
    } state_t;

    state_t            state, state_next;
    logic              mem_op;
    logic              halt_take;
    logic [DATA_W-1:0] wb_sel;

    assign mem_op         = (dmemREN_in | dmemWEN_in) & (state != HALTED);
    assign dbus.dmemWEN   = dmemWEN_in & mem_op;
    assign dbus.dmemREN   = dmemREN_in & ~dmemWEN_in & mem_op;
    assign dbus.dmemaddr  = aluResult_in;
    assign dbus.dmemstore = rdat2_in;
    assign mem_stall      = mem_op & ~dbus.dhit;
    assign halt_take      = halt_in & ~mem_stall & (state != HALTED);

    always_comb begin
        state_next = state;
        // A registered halt wins over WAIT->RUN so state and the halt flag never disagree.
        unique case (state)
            RUN: begin
                if (halt_take)      state_next = HALTED;
                else if (mem_stall) state_next = WAIT_HIT;
            end
            WAIT_HIT: begin
                if (halt_take)                   state_next = HALTED;
                else if (dbus.dhit || !mem_op)   state_next = RUN;
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        wb_sel = aluResult_in;
        unique case (memtoreg_in)
            2'b00:   wb_sel = aluResult_in;
            2'b01:   wb_sel = dbus.dmemload;
            2'b10:   wb_sel = npc_in;
            2'b11:   wb_sel = upper16_in;
            default: wb_sel = aluResult_in;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= state_next;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_regwrite  <= 1'b0;
            wb_wsel      <= '0;
            wb_wdat      <= '0;
            halt         <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (state == HALTED || mem_stall) begin
                wb_regwrite <= 1'b0;
            end else begin
                wb_regwrite <= regwrite_in & ~halt_in;
                wb_wsel     <= branchDest_in;
                wb_wdat     <= wb_sel;
            end
            if (halt_take)
                halt <= 1'b1;
            if (mem_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
